// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : fifo_pkg                                                      |
// | Purpose    : Shared types, width helper and elaboration-check messages     |
// |              for the single-clock FIFO family (sync_fifo_flex).            |
// | Contents   : fifo_mode_e    - read mode (standard / first-word-fall-through)|
// |              fifo_cnt_width - width of a fill counter for a given address  |
// |              MSG_*          - text used by elaboration-time checks         |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // A fill count must represent 0..2**aw inclusive, hence one extra bit.
  function automatic int fifo_cnt_width(input int aw);
    return aw + 1;
  endfunction

  localparam string MSG_DEPTH  = "sync_fifo_flex: DEPTH must equal 2**ADDR_WIDTH";
  localparam string MSG_AFULL  = "sync_fifo_flex: AFULL_THRESH must lie in 0..DEPTH";
  localparam string MSG_AEMPTY = "sync_fifo_flex: AEMPTY_THRESH must lie in 0..DEPTH";

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_sdp_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : fifo_sdp_ram                                                  |
// | Purpose    : Simple dual-port storage, one write port and one registered   |
// |              read port, DATA_WIDTH x 2**ADDR_WIDTH.                         |
// | Ports      : clk      - clock, rising edge                                 |
// |              rst      - synchronous active-high reset (read register only) |
// |              we_i     - write enable                                       |
// |              waddr_i  - write address                                      |
// |              wdata_i  - write data                                         |
// |              re_i     - read enable; loads rdata_o on the next edge        |
// |              raddr_i  - read address                                       |
// |              rdata_o  - registered read data, holds when re_i is low       |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module fifo_sdp_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:(1 << ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage array is deliberately not reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : fifo_sdp_ram
`default_nettype wire

// File: rtl/sync_fifo_flex.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : sync_fifo_flex                                                |
// | Purpose    : Single-clock parametrised FIFO with fill count, programmable  |
// |              almost-full / almost-empty flags and standard or FWFT read.   |
// | Ports      : clk, rst (sync, active high)                                  |
// |              wr_en, din          - write side, accepted when !full         |
// |              rd_en, dout         - read side, accepted when !empty         |
// |              full, empty, almost_full, almost_empty, count - registered    |
// |              overflow, underflow - sticky error flags                      |
// | Options    : macro SYNC_FIFO_ERR_EN enables overflow/underflow detection;  |
// |              when undefined both outputs are tied low.                     |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module sync_fifo_flex
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int DEPTH         = 1 << ADDR_WIDTH,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  wr_en,
  input  logic [DATA_WIDTH-1:0]                 din,
  input  logic                                  rd_en,
  output logic [DATA_WIDTH-1:0]                 dout,
  output logic                                  full,
  output logic                                  empty,
  output logic                                  almost_full,
  output logic                                  almost_empty,
  output logic [fifo_cnt_width(ADDR_WIDTH)-1:0] count,
  output logic                                  overflow,
  output logic                                  underflow
);

  localparam int             CW       = fifo_cnt_width(ADDR_WIDTH);
  localparam fifo_mode_e     MODE     = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [CW-1:0]  C_DEPTH  = CW'(DEPTH);
  localparam logic [CW-1:0]  C_AFULL  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0]  C_AEMPTY = CW'(AEMPTY_THRESH);

  // ---------------------------------------------------------------- checks
  if (DEPTH != (1 << ADDR_WIDTH)) begin : g_chk_depth
    $error("%s", MSG_DEPTH);
  end
  if ((AFULL_THRESH < 0) || (AFULL_THRESH > DEPTH)) begin : g_chk_afull
    $error("%s", MSG_AFULL);
  end
  if ((AEMPTY_THRESH < 0) || (AEMPTY_THRESH > DEPTH)) begin : g_chk_aempty
    $error("%s", MSG_AEMPTY);
  end

  // ---------------------------------------------------------------- state
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ram_re;
  logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
  logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  afull_q, aempty_q;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign wr_acc = wr_en & ~full_q;

  // rd_acc is a pop as seen by the user; ram_re is a read of the storage
  // array. They coincide in standard mode but not in FWFT mode.
  always_comb begin
    wptr_d  = wptr_q + {{ADDR_WIDTH{1'b0}}, wr_acc};
    rptr_d  = rptr_q + {{ADDR_WIDTH{1'b0}}, ram_re};
    count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
  end

  if (MODE == FIFO_FWFT) begin : g_fwft
    // The RAM read register doubles as the prefetch register: valid_q says
    // it currently holds the head word. count_q includes that word, so the
    // RAM itself holds count_q - valid_q words.
    logic          valid_q, valid_d;
    logic [CW-1:0] ram_words;

    always_comb begin
      ram_words = count_q - CW'(valid_q);
      rd_acc    = rd_en & valid_q;
      // Refill the head whenever it is empty or being popped this cycle,
      // which keeps dout streaming without a bubble.
      ram_re    = (ram_words != '0) & (~valid_q | rd_acc);
      valid_d   = ram_re | (valid_q & ~rd_acc);
      empty_d   = ~valid_d;
      full_d    = (count_d == C_DEPTH);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_d;
      end
    end
  end else begin : g_std
    always_comb begin
      rd_acc  = rd_en & ~empty_q;
      ram_re  = rd_acc;
      empty_d = (wptr_d == rptr_d);
      full_d  = (wptr_d[ADDR_WIDTH] != rptr_d[ADDR_WIDTH]) &&
                (wptr_d[ADDR_WIDTH-1:0] == rptr_d[ADDR_WIDTH-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= (count_d >= C_AFULL);
      aempty_q <= (count_d <= C_AEMPTY);
    end
  end

  fifo_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_acc),
    .waddr_i (wptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (din),
    .re_i    (ram_re),
    .raddr_i (rptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (ram_rdata)
  );

  assign dout         = ram_rdata;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;

  // ---------------------------------------------------------------- errors
`ifdef SYNC_FIFO_ERR_EN
  logic ovf_q, unf_q;

  // empty_q means "nothing at dout" in both modes, so it qualifies reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_en & full_q) begin
        ovf_q <= 1'b1;
      end
      if (rd_en & empty_q) begin
        unf_q <= 1'b1;
      end
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule : sync_fifo_flex
`default_nettype wire

// File: tb/tb_sync_fifo_flex.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_sync_fifo_flex                                             |
// | Purpose    : Self-checking bench for sync_fifo_flex; one standard-mode and |
// |              one FWFT-mode instance, 8-bit x 16-word configuration.        |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_sync_fifo_flex;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  // standard-mode instance
  logic       wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  // FWFT instance
  logic       wr_f = 1'b0, rd_f = 1'b0;
  logic [7:0] din_f = '0;
  logic [7:0] dout_f;
  logic       full_f, empty_f, afull_f, aempty_f, ovf_f, unf_f;
  logic [4:0] count_f;

  sync_fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) dut_fw (
    .clk(clk), .rst(rst), .wr_en(wr_f), .din(din_f), .rd_en(rd_f), .dout(dout_f),
    .full(full_f), .empty(empty_f), .almost_full(afull_f), .almost_empty(aempty_f),
    .count(count_f), .overflow(ovf_f), .underflow(unf_f)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // scoreboard / reference model for the standard-mode instance
  logic [7:0] sb[$];
  logic [7:0] sb_f[$];
  int         m_cnt  = 0;
  logic [7:0] m_dout = 8'h00;
  logic       m_ovf  = 1'b0;
  logic       m_unf  = 1'b0;

  // One clock of standard-mode stimulus; the model follows the accepted ops.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    bit w_ok;
    bit r_ok;
    wr_en = w; din = d; rd_en = r;
    w_ok = w && (m_cnt < 16);
    r_ok = r && (m_cnt > 0);
    @(posedge clk); #1;
`ifdef SYNC_FIFO_ERR_EN
    if (w && !w_ok) m_ovf = 1'b1;
    if (r && !r_ok) m_unf = 1'b1;
`endif
    if (r_ok) m_dout = sb.pop_front();
    if (w_ok) sb.push_back(d);
    m_cnt = m_cnt + int'(w_ok) - int'(r_ok);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic cyc_f(input logic w, input logic [7:0] d, input logic r);
    wr_f = w; din_f = d; rd_f = r;
    @(posedge clk); #1;
    wr_f = 1'b0; rd_f = 1'b0;
  endtask

  task automatic pulse_reset(input logic w);
    rst = 1'b1; wr_en = w; din = 8'hEE;
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0;
    sb.delete(); sb_f.delete();
    m_cnt = 0; m_dout = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset(1'b0);
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_cmp++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_aempty: got %b want 1", almost_empty); end
    n_cmp++; if (full !== 1'b0 || almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b/%b want 0/0", full, almost_full); end
    n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
    n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b/%b want 0/0", overflow, underflow); end
    n_cmp++; if (empty_f !== 1'b1 || count_f !== 5'd0 || dout_f !== 8'h00) begin
      n_fail++; $display("FAIL reset_fwft: got empty=%b count=%0d dout=%h want 1/0/00", empty_f, count_f, dout_f);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      n_cmp++; if (count !== 5'(m_cnt)) begin n_fail++; $display("FAIL fill_count: got %0d want %0d", count, m_cnt); end
      n_cmp++; if (almost_full !== (m_cnt >= 14)) begin n_fail++; $display("FAIL fill_afull@%0d: got %b want %b", m_cnt, almost_full, m_cnt >= 14); end
      n_cmp++; if (full !== (m_cnt == 16)) begin n_fail++; $display("FAIL fill_full@%0d: got %b want %b", m_cnt, full, m_cnt == 16); end
      n_cmp++; if (empty !== 1'b0) begin n_fail++; $display("FAIL fill_empty@%0d: got %b want 0", m_cnt, empty); end
    end
    cyc(1'b1, 8'hFF, 1'b0);
    n_cmp++; if (count !== 5'd16 || full !== 1'b1) begin n_fail++; $display("FAIL overflow_drop: got count=%0d full=%b want 16/1", count, full); end
    n_cmp++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL overflow_flag: got %b want %b", overflow, m_ovf); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      n_cmp++; if (dout !== m_dout) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, dout, m_dout); end
      n_cmp++; if (empty !== (m_cnt == 0)) begin n_fail++; $display("FAIL drain_empty@%0d: got %b want %b", m_cnt, empty, m_cnt == 0); end
      n_cmp++; if (almost_empty !== (m_cnt <= 2)) begin n_fail++; $display("FAIL drain_aempty@%0d: got %b want %b", m_cnt, almost_empty, m_cnt <= 2); end
    end
    cyc(1'b0, 8'h00, 1'b1);
    n_cmp++; if (dout !== 8'h10) begin n_fail++; $display("FAIL underflow_hold: got %h want 10", dout); end
    n_cmp++; if (underflow !== m_unf || overflow !== m_ovf) begin
      n_fail++; $display("FAIL underflow_flag: got unf=%b ovf=%b want %b/%b", underflow, overflow, m_unf, m_ovf);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    d = 8'h30;
    for (int i = 0; i < 5; i++) begin cyc(1'b1, d, 1'b0); d = d + 8'd1; end
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, d, 1'b1); d = d + 8'd1;
      n_cmp++; if (count !== 5'd5) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d want 5", i, count); end
      n_cmp++; if (dout !== m_dout) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, dout, m_dout); end
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      n_cmp++; if (dout !== m_dout) begin n_fail++; $display("FAIL b2b_tail[%0d]: got %h want %h", i, dout, m_dout); end
    end
    n_cmp++; if (empty !== 1'b1 || count !== 5'd0) begin n_fail++; $display("FAIL b2b_end: got empty=%b count=%0d want 1/0", empty, count); end
  endtask

  task automatic test_fwft();
    cyc_f(1'b1, 8'hA5, 1'b0);
    n_cmp++; if (empty_f !== 1'b1 || count_f !== 5'd1) begin n_fail++; $display("FAIL fwft_lat1: got empty=%b count=%0d want 1/1", empty_f, count_f); end
    cyc_f(1'b0, 8'h00, 1'b0);
    n_cmp++; if (dout_f !== 8'hA5 || empty_f !== 1'b0) begin n_fail++; $display("FAIL fwft_head: got dout=%h empty=%b want a5/0", dout_f, empty_f); end
    cyc_f(1'b0, 8'h00, 1'b1);
    n_cmp++; if (empty_f !== 1'b1 || count_f !== 5'd0) begin n_fail++; $display("FAIL fwft_pop: got empty=%b count=%0d want 1/0", empty_f, count_f); end
    for (int i = 0; i < 3; i++) begin cyc_f(1'b1, 8'hB0 + 8'(i), 1'b0); sb_f.push_back(8'hB0 + 8'(i)); end
    cyc_f(1'b0, 8'h00, 1'b0);
    cyc_f(1'b0, 8'h00, 1'b0);
    n_cmp++; if (dout_f !== sb_f[0] || count_f !== 5'd3) begin n_fail++; $display("FAIL fwft_burst_head: got dout=%h count=%0d want %h/3", dout_f, count_f, sb_f[0]); end
    for (int i = 0; i < 3; i++) begin
      cyc_f(1'b0, 8'h00, 1'b1);
      void'(sb_f.pop_front());
      if (sb_f.size() > 0) begin
        n_cmp++; if (dout_f !== sb_f[0] || empty_f !== 1'b0) begin n_fail++; $display("FAIL fwft_stream[%0d]: got dout=%h empty=%b want %h/0", i, dout_f, empty_f, sb_f[0]); end
      end else begin
        n_cmp++; if (empty_f !== 1'b1 || count_f !== 5'd0) begin n_fail++; $display("FAIL fwft_stream_end: got empty=%b count=%0d want 1/0", empty_f, count_f); end
      end
    end
  endtask

  task automatic test_mid_reset();
    pulse_reset(1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b1, 8'h40 + 8'(i), 1'b0);
    n_cmp++; if (count !== 5'd9) begin n_fail++; $display("FAIL midrst_pre: got %0d want 9", count); end
    pulse_reset(1'b1);
    n_cmp++; if (count !== 5'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL midrst_post: got count=%0d empty=%b want 0/1", count, empty); end
    cyc(1'b1, 8'h77, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    n_cmp++; if (dout !== m_dout || m_dout !== 8'h77) begin n_fail++; $display("FAIL midrst_data: got %h want 77", dout); end
    n_cmp++; if (empty !== 1'b1 || count !== 5'd0) begin n_fail++; $display("FAIL midrst_end: got empty=%b count=%0d want 1/0", empty, count); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_fwft();
    test_mid_reset();
    test_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_sync_fifo_flex
`default_nettype wire
